// File: rtl/signed_sort_ctrl_if.sv
// rtl/signed_sort_ctrl_if.sv - element-in / sorted-out valid/ready bundle for signed_sort_ctrl
interface signed_sort_ctrl_if;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_ready;
    logic       busy;
    logic [5:0] swap_count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, swap_count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, swap_count
    );
endinterface

// File: rtl/signed_sort_ctrl.sv
// rtl/signed_sort_ctrl.sv - load / bubble-sort (signed 4-bit, ascending) / drain frame controller
// Optional SORT_EARLY_EXIT_EN: leave SORT after the first pass that performs no swap.
module signed_sort_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    signed_sort_ctrl_if.slave  bus
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DEPTH - 1);
    localparam logic [IW-1:0] LAST_PASS = IW'(DEPTH - 2);

    typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_e;

    state_e        state_q, state_d;
    logic [3:0]    mem_q [DEPTH];
    logic [3:0]    mem_d [DEPTH];
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [IW-1:0] rd_idx_q, rd_idx_d;
    logic [IW-1:0] pass_q, pass_d;
    logic [IW-1:0] j_q, j_d;
    logic [5:0]    swap_cnt_q, swap_cnt_d;
`ifdef SORT_EARLY_EXIT_EN
    logic          swapped_q, swapped_d;
`endif

    logic [IW-1:0] j_nxt;
    logic [3:0]    cmp_lo, cmp_hi;
    logic          do_swap, pass_end;

    assign bus.in_ready   = (state_q == LOAD);
    assign bus.out_valid  = (state_q == DRAIN);
    assign bus.out_data   = mem_q[rd_idx_q];
    assign bus.busy       = (state_q != LOAD);
    assign bus.swap_count = swap_cnt_q;

    always_comb begin
        state_d    = state_q;
        mem_d      = mem_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        pass_d     = pass_q;
        j_d        = j_q;
        swap_cnt_d = swap_cnt_q;
`ifdef SORT_EARLY_EXIT_EN
        swapped_d  = swapped_q;
`endif
        j_nxt    = j_q + IW'(1);
        cmp_lo   = mem_q[j_q];
        cmp_hi   = mem_q[j_nxt];
        do_swap  = $signed(cmp_hi) < $signed(cmp_lo);
        pass_end = (j_q == LAST_PASS - pass_q);

        case (state_q)
            LOAD: begin
                if (bus.in_valid) begin
                    mem_d[wr_idx_q] = bus.in_data;
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d   = '0;
                        pass_d     = '0;
                        j_d        = '0;
                        swap_cnt_d = '0;
`ifdef SORT_EARLY_EXIT_EN
                        swapped_d  = 1'b0;
`endif
                        state_d    = SORT;
                    end else begin
                        wr_idx_d = wr_idx_q + IW'(1);
                    end
                end
            end
            SORT: begin
                // Swap is committed at the compare edge so the next compare sees it.
                if (do_swap) begin
                    mem_d[j_q]   = cmp_hi;
                    mem_d[j_nxt] = cmp_lo;
                    swap_cnt_d   = swap_cnt_q + 6'd1;
`ifdef SORT_EARLY_EXIT_EN
                    swapped_d    = 1'b1;
`endif
                end
                if (pass_end) begin
                    j_d    = '0;
                    pass_d = pass_q + IW'(1);
`ifdef SORT_EARLY_EXIT_EN
                    swapped_d = 1'b0;
                    if (pass_q == LAST_PASS || !(swapped_q || do_swap)) begin
`else
                    if (pass_q == LAST_PASS) begin
`endif
                        rd_idx_d = '0;
                        state_d  = DRAIN;
                    end
                end else begin
                    j_d = j_nxt;
                end
            end
            DRAIN: begin
                if (bus.out_ready) begin
                    if (rd_idx_q == LAST_IDX) begin
                        rd_idx_d = '0;
                        state_d  = LOAD;
                    end else begin
                        rd_idx_d = rd_idx_q + IW'(1);
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LOAD;
            mem_q      <= '{default: '0};
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            pass_q     <= '0;
            j_q        <= '0;
            swap_cnt_q <= '0;
`ifdef SORT_EARLY_EXIT_EN
            swapped_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            pass_q     <= pass_d;
            j_q        <= j_d;
            swap_cnt_q <= swap_cnt_d;
`ifdef SORT_EARLY_EXIT_EN
            swapped_q  <= swapped_d;
`endif
        end
    end
endmodule

// File: tb/tb_signed_sort_ctrl.sv
// tb/tb_signed_sort_ctrl.sv - randomized and directed checks of signed_sort_ctrl against a frame-level model
module tb_signed_sort_ctrl;
    localparam int D = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    signed_sort_ctrl_if bus();

    signed_sort_ctrl #(.DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [3:0] fr    [D];
    logic [3:0] exp_s [D];
    int         exp_swaps;
    int         exp_lat;

    // Sorted order by rank, swaps as inversion count, latency from passes needed.
    function automatic void model();
        int maxd = 0;
        int passes;
        int cyc = 0;
        exp_swaps = 0;
        for (int i = 0; i < D; i++) begin
            int lt = 0;
            int eqb = 0;
            int d = 0;
            for (int k = 0; k < D; k++) begin
                if ($signed(fr[k]) < $signed(fr[i])) lt++;
                if (k < i && fr[k] == fr[i]) eqb++;
                if (k < i && $signed(fr[k]) > $signed(fr[i])) d++;
            end
            exp_s[lt + eqb] = fr[i];
            exp_swaps += d;
            if (d > maxd) maxd = d;
        end
`ifdef SORT_EARLY_EXIT_EN
        passes = (maxd >= D - 1) ? D - 1 : maxd + 1;
`else
        passes = D - 1;
`endif
        for (int p = 0; p < passes; p++) cyc += D - 1 - p;
        exp_lat = cyc + 1;
    endfunction

    task automatic set_frame(input logic [15:0] v);
        for (int i = 0; i < D; i++) fr[i] = v[15 - 4*i -: 4];
        model();
    endtask

    task automatic load_frame(input bit keep_valid);
        for (int i = 0; i < D; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = fr[i];
            @(posedge clk); #1;
        end
        if (keep_valid) bus.in_data = 4'h5;
        else bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input bit chk_blocked);
        int n = 1;
        while (!bus.out_valid && n < 200) begin
            if (chk_blocked) begin
                n_total++;
                if (bus.in_ready !== 1'b0) $display("FAIL %s sort_in_ready got=%b want=0", tag, bus.in_ready);
                else n_pass++;
            end
            @(posedge clk); #1;
            n++;
        end
        n_total++;
        if (n !== exp_lat) $display("FAIL %s drain_latency got=%0d want=%0d", tag, n, exp_lat);
        else n_pass++;
    endtask

    task automatic drain(input string tag, input bit rand_ready, input int hold, input bit chk_blocked);
        int got = 0;
        int cyc = 0;
        bit rdy;
        while (got < D && cyc < 200) begin
            rdy = rand_ready ? 1'($urandom_range(0, 1)) : (cyc >= hold);
            bus.out_ready = rdy;
            n_total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_s[got])
                $display("FAIL %s drain[%0d] got v=%b d=%h want v=1 d=%h", tag, got, bus.out_valid, bus.out_data, exp_s[got]);
            else n_pass++;
            if (chk_blocked) begin
                n_total++;
                if (bus.in_ready !== 1'b0) $display("FAIL %s drain_in_ready got=%b want=0", tag, bus.in_ready);
                else n_pass++;
            end
            @(posedge clk); #1;
            if (rdy) got++;
            cyc++;
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        n_total++;
        if (got !== D) $display("FAIL %s drain_timeout got=%0d want=%0d", tag, got, D);
        else n_pass++;
        n_total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL %s post_drain got rdy=%b ov=%b busy=%b want 1 0 0", tag, bus.in_ready, bus.out_valid, bus.busy);
        else n_pass++;
        n_total++;
        if (bus.swap_count !== 6'(exp_swaps))
            $display("FAIL %s swap_count got=%0d want=%0d", tag, bus.swap_count, exp_swaps);
        else n_pass++;
    endtask

    task automatic run_frame(input string tag, input logic [15:0] v);
        set_frame(v);
        load_frame(1'b0);
        wait_drain(tag, 1'b0);
        drain(tag, 1'b0, 0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        n_total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 4'h0 ||
            bus.busy !== 1'b0 || bus.swap_count !== 6'd0)
            $display("FAIL reset got rdy=%b ov=%b od=%h busy=%b sc=%0d want 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.busy, bus.swap_count);
        else n_pass++;
    endtask

    task automatic test_directed();
        run_frame("mixed",    16'h3F78);
        run_frame("sorted",   16'h8F07);
        run_frame("reversed", 16'h7308);
        run_frame("equal",    16'h22EE);
    endtask

    task automatic test_random();
        for (int f = 0; f < 20; f++) begin
            set_frame(16'($urandom));
            load_frame(1'b0);
            wait_drain("random", 1'b0);
            drain("random", 1'b1, 0, 1'b0);
        end
    endtask

    task automatic test_backpressure();
        set_frame(16'h3F78);
        load_frame(1'b0);
        wait_drain("bp", 1'b0);
        drain("bp", 1'b0, 3, 1'b0);
    endtask

    task automatic test_input_block();
        set_frame(16'h1C9A);
        load_frame(1'b1);
        wait_drain("blk", 1'b1);
        drain("blk", 1'b0, 2, 1'b1);
        set_frame(16'h4A0C);
        for (int i = 0; i < D; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = fr[i];
            @(posedge clk); #1;
            n_total++;
            if (bus.busy !== (i == D - 1))
                $display("FAIL blk_count busy after %0d accepts got=%b want=%b", i + 1, bus.busy, (i == D - 1));
            else n_pass++;
        end
        bus.in_valid = 1'b0;
        wait_drain("blk2", 1'b0);
        drain("blk2", 1'b0, 0, 1'b0);
    endtask

    task automatic test_mid_sort_reset();
        set_frame(16'h3F78);
        load_frame(1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.swap_count !== 6'd0 || bus.out_data !== 4'h0)
            $display("FAIL midsort_reset got rdy=%b ov=%b busy=%b sc=%0d od=%h want 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.swap_count, bus.out_data);
        else n_pass++;
        run_frame("after_reset", 16'h1000);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_input_block();
        test_mid_sort_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
